// File: rtl/opb_register_simulink2ppc.sv
// -----------------------------------------------------------------------------
// opb_register_simulink2ppc
//   OPB slave that publishes a fabric value to the processor. The fabric side
//   strobes user_data_valid to capture user_data_in into DATA and set NEW. The
//   processor reads DATA, which clears NEW, and can FREEZE captures through
//   CTRL.
//
//   Register map (byte offsets from C_BASEADDR, decoded per 32-bit word):
//     0x0 DATA  RO  captured value
//     0x4 CTRL  bit31 NEW (RO), bit30 FREEZE (RW, byte lane 3)
//     0x8 OVR   RO  overrun count (only when OPB_S2P_OVERRUN_CNT_EN is defined)
//     other     reads 0, writes ignored
//   CTRL/OVR bit numbers use OPB (big-endian) numbering. On the [0:31] bus,
//   NEW is therefore numeric bit 0 and FREEZE is numeric bit 1. The DATA value
//   maps straight through: user bit n appears on OPB bit 31-n.
//
//   Optional feature macro: OPB_S2P_OVERRUN_CNT_EN. When it is defined, OVR is a
//   16-bit saturating counter of captures that overwrote unread data. A read of
//   OVR clears it.
//
// Ports
//   OPB_Clk, OPB_Rst_n         clock, async active-low reset
//   OPB_ABus/BE/DBus/RNW/
//   OPB_select/OPB_seqAddr     OPB master request (seqAddr ignored)
//   Sl_DBus/xferAck/errAck/
//   Sl_retry/Sl_toutSup        slave response (errAck/retry/toutSup tied 0)
//   user_data_in, user_data_valid  fabric capture port
// -----------------------------------------------------------------------------
module opb_register_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h01004100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010041FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic [31:0]               user_data_in,
  input  logic                      user_data_valid
);

  localparam logic [5:0] W_DATA = 6'd0;
  localparam logic [5:0] W_CTRL = 6'd1;
  localparam logic [5:0] W_OVR  = 6'd2;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ACK, S_HOLD} state_e;

  // Request latched on entry to DECODE. OPB numbering is kept for BE and data.
  typedef struct packed {
    logic [5:0]  widx;
    logic        rnw;
    logic [0:3]  be;
    logic [0:31] wdata;
  } req_t;

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] data_q, data_d;
  logic        new_q, new_d;
  logic        freeze_q, freeze_d;
  logic        blk_q, blk_d;

  logic [31:0] abus_off;
  logic        hit;
  logic        capture;
  logic        ack_rd_data;
  logic        ack_wr_ctrl;
  logic [31:0] ovr_rd;

  assign abus_off = OPB_ABus - C_BASEADDR;

  // blk_q is set by reset and clears once select is seen low. A select that
  // was already high across reset therefore cannot start a transfer.
  assign hit = OPB_select && !blk_q &&
               (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);

  assign capture     = user_data_valid && !freeze_q;
  assign ack_rd_data = (state_q == S_ACK) && req_q.rnw && (req_q.widx == W_DATA);
  assign ack_wr_ctrl = (state_q == S_ACK) && !req_q.rnw &&
                       (req_q.widx == W_CTRL) && req_q.be[3];

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (hit) state_d = S_DECODE;
      S_DECODE: state_d = S_ACK;
      S_ACK:    state_d = S_HOLD;
      S_HOLD:   if (!OPB_select) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_d = req_q;
    if (state_q == S_IDLE && hit) begin
      req_d.widx  = abus_off[7:2];
      req_d.rnw   = OPB_RNW;
      req_d.be    = OPB_BE[0:3];
      req_d.wdata = OPB_DBus[0:31];
    end
  end

  // Read data is frozen in DECODE so Sl_DBus cannot change mid-ACK even if a
  // capture lands during the ACK cycle.
  always_comb begin
    rdata_d = rdata_q;
    if (state_q == S_DECODE) begin
      unique case (req_q.widx)
        W_DATA:  rdata_d = data_q;
        W_CTRL:  rdata_d = {30'b0, freeze_q, new_q};
        W_OVR:   rdata_d = ovr_rd;
        default: rdata_d = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register file. A capture has priority over the NEW clear from a DATA read,
  // so a value arriving during that ACK is never lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d   = data_q;
    new_d    = new_q;
    freeze_d = freeze_q;
    blk_d    = blk_q && OPB_select;
    if (capture) begin
      data_d = user_data_in;
      new_d  = 1'b1;
    end else if (ack_rd_data) begin
      new_d  = 1'b0;
    end
    if (ack_wr_ctrl) freeze_d = req_q.wdata[30];
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      rdata_q  <= '0;
      data_q   <= '0;
      new_q    <= 1'b0;
      freeze_q <= 1'b0;
      blk_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      rdata_q  <= rdata_d;
      data_q   <= data_d;
      new_q    <= new_d;
      freeze_q <= freeze_d;
      blk_q    <= blk_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Overrun counter
  // ---------------------------------------------------------------------------
`ifdef OPB_S2P_OVERRUN_CNT_EN
  logic [15:0] ovr_q, ovr_d;
  logic        ack_rd_ovr;

  assign ack_rd_ovr = (state_q == S_ACK) && req_q.rnw && (req_q.widx == W_OVR);

  // An accepted capture over unread data counts. On a clear/increment
  // collision the increment wins, so no overrun goes unreported.
  always_comb begin
    ovr_d = ovr_q;
    if (capture && new_q) begin
      if (ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;
    end else if (ack_rd_ovr) begin
      ovr_d = '0;
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) ovr_q <= '0;
    else            ovr_q <= ovr_d;
  end

  assign ovr_rd = {16'b0, ovr_q};
`else
  assign ovr_rd = '0;
`endif

  // ---------------------------------------------------------------------------
  // Slave response. Outside a read ACK the data bus is driven to 0, because
  // OPB slave data buses are ORed together.
  // ---------------------------------------------------------------------------
  assign Sl_xferAck = (state_q == S_ACK);
  assign Sl_DBus    = (state_q == S_ACK && req_q.rnw) ? rdata_q : '0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  // Request bits that carry no register function.
  logic unused_bits;
  assign unused_bits = ^{OPB_seqAddr, abus_off[31:8], abus_off[1:0],
                         req_q.be[0:2], req_q.wdata[0:29], req_q.wdata[31]};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h01004100;
`ifdef OPB_S2P_OVERRUN_CNT_EN
  localparam bit OVR_ON = 1'b1;
`else
  localparam bit OVR_ON = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [0:31] abus = '0;
  logic [0:3]  be = '0;
  logic [0:31] dbus = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seq = 1'b0;
  logic [0:31] sl_dbus;
  logic        sl_ack, sl_err, sl_retry, sl_tout;
  logic [31:0] udata = '0;
  logic        uvalid = 1'b0;

  int   tests = 0;
  int   fails = 0;
  int   ack_cnt = 0;
  bit   mon_en = 1'b0;
  exp_t sbq[$];

  opb_register_simulink2ppc dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n),
    .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus), .OPB_RNW(rnw),
    .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(sl_dbus), .Sl_xferAck(sl_ack), .Sl_errAck(sl_err),
    .Sl_retry(sl_retry), .Sl_toutSup(sl_tout),
    .user_data_in(udata), .user_data_valid(uvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every ack, otherwise the bus must be idle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("tied_low", {29'b0, sl_err, sl_retry, sl_tout}, 32'h0);
      if (sl_ack === 1'b1) begin
        exp_t e;
        ack_cnt++;
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ack: got ack with data %08h expected no ack", sl_dbus);
        end else begin
          e = sbq.pop_front();
          check(e.name, sl_dbus, e.data);
        end
      end else begin
        check("idle_dbus", sl_dbus, 32'h0);
      end
    end
  end

  task automatic xfer(input logic [7:0] off, input logic r, input logic [0:3] b,
                      input logic [31:0] wd, input logic [31:0] exp, input string name);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    abus = BASE + {24'b0, off};
    rnw  = r; be = b; dbus = wd; sel = 1'b1;
    e.name = name; e.data = r ? exp : 32'h0;
    sbq.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sl_ack === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no ack expected ack within 8 cycles", name);
      void'(sbq.pop_back());
    end
    @(posedge clk); #1;
    sel = 1'b0; rnw = 1'b0; dbus = '0; be = '0;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    xfer(off, 1'b1, 4'b1111, 32'h0, exp, name);
  endtask

  task automatic wr(input logic [7:0] off, input logic [0:3] b, input logic [31:0] wd,
                    input string name);
    xfer(off, 1'b0, b, wd, 32'h0, name);
  endtask

  task automatic pulse(input logic [31:0] v);
    @(posedge clk); #1;
    udata = v; uvalid = 1'b1;
    @(posedge clk); #1;
    uvalid = 1'b0;
  endtask

  initial begin
    int acks0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Reset state
    rd(8'h00, 32'h0, "rst_data");
    rd(8'h04, 32'h0, "rst_ctrl");
    rd(8'h08, 32'h0, "rst_ovr");

    // Capture and read
    pulse(32'hDEADBEEF);
    rd(8'h04, 32'h0000_0001, "ctrl_new_set");
    rd(8'h00, 32'hDEADBEEF, "data_capture");
    rd(8'h04, 32'h0, "ctrl_new_clr");

    // Unmapped offsets and RO registers
    rd(8'h10, 32'h0, "unmapped_rd");
    wr(8'h10, 4'b1111, 32'hFFFFFFFF, "unmapped_wr");
    wr(8'h00, 4'b1111, 32'hFFFFFFFF, "data_wr");
    rd(8'hFC, 32'h0, "top_of_window");
    rd(8'h00, 32'hDEADBEEF, "data_ro");
    rd(8'h04, 32'h0, "ctrl_after_ro");

    // Freeze
    wr(8'h04, 4'b0001, 32'h0000_0002, "freeze_wr");
    rd(8'h04, 32'h0000_0002, "freeze_set");
    pulse(32'h12345678);
    rd(8'h00, 32'hDEADBEEF, "frozen_data");
    rd(8'h04, 32'h0000_0002, "frozen_new");
    wr(8'h04, 4'b0001, 32'h0, "unfreeze_wr");
    wr(8'h04, 4'b1110, 32'h0000_0002, "freeze_wr_be");
    rd(8'h04, 32'h0, "freeze_be_masked");
    pulse(32'hA5A5A5A5);
    rd(8'h00, 32'hA5A5A5A5, "unfrozen_data");

    // Collision: capture in the ack cycle of a DATA read
    pulse(32'h11);
    fork
      rd(8'h00, 32'h11, "coll_read");
      begin
        for (int k = 0; k < 10; k++) begin
          @(posedge clk); #1;
          if (sl_ack === 1'b1) begin
            udata = 32'h55; uvalid = 1'b1;
            @(posedge clk); #1;
            uvalid = 1'b0;
            break;
          end
        end
      end
    join
    rd(8'h04, 32'h0000_0001, "coll_new");
    rd(8'h00, 32'h55, "coll_data");
    rd(8'h08, OVR_ON ? 32'h1 : 32'h0, "coll_ovr");

    // Overrun
    pulse(32'h1);
    pulse(32'h2);
    pulse(32'h3);
    rd(8'h08, OVR_ON ? 32'h2 : 32'h0, "ovr_count");
    rd(8'h08, 32'h0, "ovr_clr");
    rd(8'h00, 32'h3, "ovr_data");

    // Reset mid-transaction, in DECODE, with select held through reset
    pulse(32'h77);
    wr(8'h04, 4'b0001, 32'h0000_0002, "pre_rst_freeze");
    @(posedge clk); #1;
    abus = BASE; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
    acks0 = ack_cnt;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_ack", {31'b0, sl_ack}, 32'h0);
    check("rst_dbus", sl_dbus, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_spurious_ack", ack_cnt - acks0, 32'h0);
    sel = 1'b0; rnw = 1'b0; be = '0;
    repeat (2) @(posedge clk);
    rd(8'h00, 32'h0, "post_rst_data");
    rd(8'h04, 32'h0, "post_rst_ctrl");
    rd(8'h08, 32'h0, "post_rst_ovr");
    pulse(32'h99);
    rd(8'h00, 32'h99, "post_rst_capture");

    repeat (3) @(posedge clk);
    check("sb_drained", sbq.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
